mem_burst_reader: RTL and testbench
===================================

# mem_burst_reader

Read initiator for the pseudo dual-port memory's read port. It accepts a burst command (start address, length) and issues one read request per cycle to the latency-`DATA_LAT` memory read port. It collects the returned words in an internal FIFO and delivers them as a valid/ready stream with a last-beat marker. The memory read port cannot be stalled, so the block throttles requests with credits: it never issues a request unless FIFO space is reserved for the response.

## Interface
- `DATA_WIDTH`, default 32: memory word width.
- `ADDR_WIDTH`, default 4: memory address width. Addresses wrap modulo 2^`ADDR_WIDTH`.
- `DATA_LAT`, default 2: memory read latency in cycles, from `r_avalid` to `r_dvalid`. Must be ≥ 1.
- `FIFO_DEPTH`, default 4: response buffer entries. Must be ≥ 1. Full throughput requires ≥ `DATA_LAT`+2.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `cmd_valid`, input, 1: burst command valid.
- `cmd_ready`, output, 1: block idle, command accepted on `cmd_valid && cmd_ready`.
- `cmd_addr`, input, `ADDR_WIDTH`: burst start address.
- `cmd_len`, input, `ADDR_WIDTH`+1: number of words, 0..2^`ADDR_WIDTH`.
- `r_addr`, output, `ADDR_WIDTH`: memory read address.
- `r_avalid`, output, 1: memory read request.
- `r_dvalid`, input, 1: memory read data valid.
- `r_data`, input, `DATA_WIDTH`: memory read data.
- `out_valid`, output, 1: output beat valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_data`, output, `DATA_WIDTH`: output word.
- `out_last`, output, 1: final beat of the burst.
- `busy`, output, 1: burst in progress (equals !`cmd_ready`).

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - ISSUE: requests outstanding to be sent.
  - DRAIN: all requests sent; waiting for the last beat to leave.
- IDLE transitions on command handshake:
  - `cmd_len`=0: command consumed, stays IDLE, no requests, no output.
  - Otherwise: latch `cmd_addr` into `next_addr` and `cmd_len` into `req_left` and `beat_left`; go to ISSUE.
- ISSUE:
  - Issue a request when credit is available: `fifo_count + inflight < FIFO_DEPTH`.
  - On issue: `r_avalid`=1, `r_addr`=`next_addr`; then `next_addr` increments (wrapping 2^`ADDR_WIDTH`-1 → 0), `req_left` decrements, `inflight` increments.
  - When the final request is issued, go to DRAIN.
- Response path:
  - `r_dvalid`=1 writes `r_data` to the FIFO and decrements `inflight`.
  - Credits guarantee the FIFO never overflows. Overflow is an assertion failure.
- Output path:
  - `out_valid` = FIFO not empty. `out_data` = FIFO head.
  - `out_last` = 1 when `beat_left`==1.
  - Each `out_valid && out_ready` handshake pops the FIFO and decrements `beat_left`.
- DRAIN: exits to IDLE on the handshake with `out_last`=1.
- Simultaneous issue and response in one cycle: `inflight` is unchanged.
- Simultaneous push and pop in one cycle: `fifo_count` is unchanged.
- `r_dvalid` while IDLE is ignored and the data dropped. Response order always equals request order.
- `cmd_len` = 2^`ADDR_WIDTH` reads every location exactly once.

## Timing
- Reset values: `cmd_ready`=1, `busy`=0, `r_avalid`=0, `r_addr`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- Reset clears all counters and empties the FIFO. Reset mid-burst abandons the burst; no further beats are output. Memory shares `rst`, so no stale responses return.
- All outputs are registered or FIFO-driven; there are no combinational input-to-output paths.
- Command handshake in cycle 0 gives:
  - First `r_avalid` in cycle 1.
  - `r_dvalid` in cycle 1+`DATA_LAT`.
  - First `out_valid` in cycle 2+`DATA_LAT`.
- Throughput with `out_ready` held high and `FIFO_DEPTH` ≥ `DATA_LAT`+2: one word per cycle.
- `cmd_ready` returns in the cycle after the last-beat handshake.

## Structure
- Package `mem_rd_pkg` holds:
  - the state enum `mem_rd_state_t` (IDLE, ISSUE, DRAIN);
  - a `clog2`-based counter-width helper for `inflight`, `fifo_count`, and length counters.
- Sub-module `sync_fifo` (parameters `DATA_WIDTH`, `DEPTH`):
  - circular buffer with read/write pointers and count;
  - outputs empty/full;
  - synchronous active-high reset.
- Top level contains the FSM, address/length counters, and credit logic.

## Test plan
Defaults apply unless stated. Memory is preloaded with mem[i] = 0xA5A5_0000 + i.
- Single-beat read: `cmd_addr`=3, `cmd_len`=1, `out_ready`=1.
  - Cycle 1: `r_avalid`=1 with `r_addr`=3.
  - Cycle 4: `out_valid`=1, `out_data`=0xA5A5_0003, `out_last`=1.
  - Cycle 5: `cmd_ready`=1.
- Streaming read: `cmd_addr`=0, `cmd_len`=8, `out_ready`=1.
  - `r_avalid` is high for 8 consecutive cycles.
  - Output is 8 consecutive beats 0xA5A5_0000..0007; `out_last` is set only on the 8th.
- Address wrap: `cmd_addr`=14, `cmd_len`=4.
  - `r_addr` sequence is 14, 15, 0, 1.
  - Data arrives in the same order; `out_last` on the 4th beat.
- Backpressure: `cmd_len`=8 with `out_ready`=0 for cycles 0–12.
  - `fifo_count + inflight` never exceeds 4; `r_avalid` stops after 4 requests.
  - After release, all 8 words are delivered in order with none lost or duplicated.
- Edge lengths:
  - `cmd_len`=0: no `r_avalid`, no output, and `cmd_ready` stays 1 throughout.
  - `cmd_len`=16 at `cmd_addr`=5: addresses 5..15 then 0..4; 16 beats with `out_last` on beat 16.
- Reset mid-burst: assert `rst` one cycle after the 3rd beat of an 8-beat burst.
  - Next cycle: `out_valid`=0, `r_avalid`=0, `cmd_ready`=1.
  - A new 2-beat command then completes correctly.

Source files
------------

// File: rtl/mem_rd_pkg.sv
// Shared types and sizing helpers for the memory burst read initiator.
package mem_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } mem_rd_state_t;

   // Bits needed to hold a counter that ranges over 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with occupancy count; the head word is presented
// combinationally and reads as zero while empty.
module sync_fifo
   import mem_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_push,
   input  logic [DATA_WIDTH-1:0]           i_data,
   input  logic                            i_pop,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic                            o_empty,
   output logic                            o_full,
   output logic [cnt_width(DEPTH)-1:0]     o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = cnt_width(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  w_wr_en;
   logic                  w_rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign w_wr_en = i_push && (!o_full || i_pop);
   assign w_rd_en = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
         assert (!(i_push && o_full && !i_pop));
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator: issues one credit-checked read per cycle to a fixed-latency
// memory port and streams the returned words out with a last-beat marker.
module mem_burst_reader
   import mem_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_LAT   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH:0]   cmd_len,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  r_avalid,
   input  logic                  r_dvalid,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy
);

   localparam int CW = cnt_width(FIFO_DEPTH);
   localparam int SW = CW + 1;
   localparam int LW = ADDR_WIDTH + 1;

   mem_rd_state_t         r_state;
   mem_rd_state_t         w_state_next;
   logic [ADDR_WIDTH-1:0] r_next_addr;
   logic [LW-1:0]         r_req_left;
   logic [LW-1:0]         r_beat_left;
   logic [CW-1:0]         r_inflight;
   logic [CW-1:0]         w_fifo_count;
   logic [SW-1:0]         w_used;
   logic                  w_cmd_fire;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_credit;
   logic                  w_issue;
   logic [ADDR_WIDTH-1:0] w_issue_addr;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;

   assign cmd_ready  = (r_state == IDLE);
   assign busy       = !cmd_ready;
   assign w_cmd_fire = cmd_valid && cmd_ready;
   assign w_push     = r_dvalid && (r_state != IDLE);
   assign out_valid  = !w_fifo_empty;
   assign w_pop      = out_valid && out_ready;
   assign out_last   = (r_beat_left == LW'(1));

   // r_avalid is registered, so the credit for a request is taken at the edge that
   // schedules it. Counting the slot freed by this cycle's pop keeps the pipeline
   // full when FIFO_DEPTH >= DATA_LAT + 2.
   assign w_used   = SW'(w_fifo_count) + SW'(r_inflight);
   assign w_credit = (w_used - SW'(w_pop)) < SW'(FIFO_DEPTH);

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_issue_addr = r_next_addr;
      case (r_state)
         IDLE: begin
            if (w_cmd_fire && (cmd_len != '0)) begin
               w_issue      = 1'b1;
               w_issue_addr = cmd_addr;
               w_state_next = (cmd_len == LW'(1)) ? DRAIN : ISSUE;
            end
         end
         ISSUE: begin
            if (w_credit) begin
               w_issue = 1'b1;
               if (r_req_left == LW'(1)) w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (w_pop && out_last) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_avalid    <= 1'b0;
         r_addr      <= '0;
         r_next_addr <= '0;
         r_req_left  <= '0;
         r_beat_left <= '0;
         r_inflight  <= '0;
      end else begin
         r_state  <= w_state_next;
         r_avalid <= w_issue;
         if (w_issue) begin
            r_addr      <= w_issue_addr;
            r_next_addr <= w_issue_addr + ADDR_WIDTH'(1);
            r_req_left  <= ((r_state == IDLE) ? cmd_len : r_req_left) - LW'(1);
         end
         if (w_cmd_fire)
            r_beat_left <= cmd_len;
         else if (w_pop)
            r_beat_left <= r_beat_left - LW'(1);
         r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
         // A request is outstanding from its scheduling edge until its response lands.
         assert (int'(r_inflight) <= DATA_LAT + 1);
      end
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (r_data),
      .i_pop   (w_pop),
      .o_data  (out_data),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full),
      .o_count (w_fifo_count)
   );

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader with a fixed-latency memory model.
module tb_mem_burst_reader;

   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int LAT = 2;
   localparam int FD  = 4;
   localparam int NW  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [AW:0]   cmd_len;
   logic [AW-1:0] r_addr;
   logic          r_avalid, r_dvalid;
   logic [DW-1:0] r_data;
   logic          out_valid, out_ready, out_last, busy;
   logic [DW-1:0] out_data;
   logic          inj;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_burst_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DATA_LAT   (LAT),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .r_addr    (r_addr),
      .r_avalid  (r_avalid),
      .r_dvalid  (r_dvalid),
      .r_data    (r_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   // Memory: each request returns mem[addr] exactly LAT cycles later.
   logic [DW-1:0]  mem [NW];
   logic [LAT-1:0] pv;
   logic [DW-1:0]  pd [LAT];

   always @(posedge clk) begin
      if (rst) begin
         pv <= '0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
         pv[0] <= r_avalid;
         pd[0] <= mem[r_addr];
      end
   end

   assign r_dvalid = pv[LAT-1] | inj;
   assign r_data   = inj ? 32'hDEAD_BEEF : pd[LAT-1];

   // Observed traffic, sampled on the falling edge.
   logic [AW-1:0] q_req[$];
   logic [DW:0]   q_out[$];
   int            q_req_cyc[$];
   int            q_out_cyc[$];
   int            cyc = 0;
   int            outstanding = 0;
   int            max_out = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         outstanding = 0;
      end else begin
         if (r_avalid) begin
            q_req.push_back(r_addr);
            q_req_cyc.push_back(cyc);
            outstanding++;
         end
         if (out_valid && out_ready) begin
            q_out.push_back({out_last, out_data});
            q_out_cyc.push_back(cyc);
            outstanding--;
         end
         if (outstanding > max_out) max_out = outstanding;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_burst(input string tag, input int addr, input int len, input int pct,
                            input int hold, input logic chk_first, input logic [DW-1:0] exp_first);
      int k;
      int nbusy;
      int a;
      q_req.delete(); q_req_cyc.delete(); q_out.delete(); q_out_cyc.delete();
      max_out = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_addr  = AW'(addr);
      cmd_len   = (AW+1)'(len);
      out_ready = (hold == 0);
      check({tag, " cmd_ready before"}, cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (len == 0) begin
         nbusy = 0;
         repeat (10) begin
            if (!cmd_ready) nbusy++;
            @(posedge clk); #1;
         end
         check({tag, " len0 busy cycles"}, nbusy, 0);
      end else begin
         for (k = 1; k < 600; k++) begin
            if (q_out.size() >= len && cmd_ready) break;
            if (hold > 0 && k == hold - 1) check({tag, " reqs while stalled"}, q_req.size(), FD);
            out_ready = (k >= hold) && ($urandom_range(0, 99) < pct);
            @(posedge clk); #1;
         end
         check({tag, " done in budget"}, k < 600, 1);
      end
      check({tag, " nreq"}, q_req.size(), len);
      check({tag, " nbeat"}, q_out.size(), len);
      for (int i = 0; i < len && i < q_req.size(); i++) begin
         a = (addr + i) % NW;
         check($sformatf("%s addr%0d", tag, i), q_req[i], a);
      end
      for (int i = 0; i < q_out.size(); i++) begin
         a = (addr + i) % NW;
         check($sformatf("%s data%0d", tag, i), q_out[i][DW-1:0], mem[a]);
         check($sformatf("%s last%0d", tag, i), q_out[i][DW], (i == len - 1));
      end
      check({tag, " credit bound"}, max_out <= FD, 1);
      check({tag, " idle after"}, cmd_ready, 1);
      if (chk_first && len > 0 && q_out.size() > 0)
         check({tag, " first word"}, q_out[0][DW-1:0], exp_first);
      if (pct == 100 && hold == 0 && len > 0 && q_req.size() == len && q_out.size() == len) begin
         check({tag, " req back-to-back"}, q_req_cyc[len-1] - q_req_cyc[0], len - 1);
         check({tag, " beat back-to-back"}, q_out_cyc[len-1] - q_out_cyc[0], len - 1);
         check({tag, " req-to-beat latency"}, q_out_cyc[0] - q_req_cyc[0], LAT + 1);
      end
   endtask

   typedef struct {
      int            addr;
      int            len;
      int            pct;
      int            hold;
      logic [DW-1:0] exp_first;
   } vec_t;

   vec_t vt[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      vt[0] = '{0,  8,  100, 0,  32'hA5A5_0000};   // streaming
      vt[1] = '{14, 4,  100, 0,  32'hA5A5_000E};   // address wrap
      vt[2] = '{0,  8,  100, 13, 32'hA5A5_0000};   // held backpressure
      vt[3] = '{5,  16, 100, 0,  32'hA5A5_0005};   // full address space
      vt[4] = '{7,  0,  100, 0,  32'h0};           // empty command
      vt[5] = '{9,  5,  50,  0,  32'hA5A5_0009};   // random backpressure

      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0; inj = 1'b0;
      for (int i = 0; i < NW; i++) mem[i] = 32'hA5A5_0000 + i;
      repeat (3) @(posedge clk);
      #1;
      check("reset cmd_ready", cmd_ready, 1);
      check("reset busy", busy, 0);
      check("reset r_avalid", r_avalid, 0);
      check("reset r_addr", r_addr, 0);
      check("reset out_valid", out_valid, 0);
      check("reset out_last", out_last, 0);
      check("reset out_data", out_data, 0);
      rst = 1'b0;

      // Single-beat timing, cycle by cycle from the command handshake.
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = 4'd3; cmd_len = 5'd1; out_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("single c1 r_avalid", r_avalid, 1);
      check("single c1 r_addr", r_addr, 3);
      check("single c1 busy", busy, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("single c3 out_valid", out_valid, 0);
      @(posedge clk); #1;
      check("single c4 out_valid", out_valid, 1);
      check("single c4 out_data", out_data, 32'hA5A5_0003);
      check("single c4 out_last", out_last, 1);
      @(posedge clk); #1;
      check("single c5 cmd_ready", cmd_ready, 1);
      check("single c5 out_valid", out_valid, 0);

      for (int i = 0; i < 6; i++)
         run_burst($sformatf("vec%0d", i), vt[i].addr, vt[i].len, vt[i].pct, vt[i].hold,
                   1'b1, vt[i].exp_first);

      // Stray responses while idle must be dropped.
      @(posedge clk); #1;
      inj = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      inj = 1'b0;
      @(posedge clk); #1;
      check("stray dvalid out_valid", out_valid, 0);
      check("stray dvalid busy", busy, 0);
      run_burst("after stray", 2, 3, 100, 0, 1'b1, 32'hA5A5_0002);

      // Reset one cycle after the third beat of an 8-beat burst.
      q_out.delete();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_addr = 4'd0; cmd_len = 5'd8; out_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (k = 0; k < 100; k++) begin
         if (q_out.size() >= 3) break;
         @(posedge clk); #1;
      end
      check("rstmid third beat seen", q_out.size() >= 3, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstmid out_valid", out_valid, 0);
      check("rstmid r_avalid", r_avalid, 0);
      check("rstmid cmd_ready", cmd_ready, 1);
      rst = 1'b0;
      run_burst("post reset", 6, 2, 100, 0, 1'b1, 32'hA5A5_0006);

      // Randomized bursts against the address/data model.
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      for (int t = 0; t < 20; t++)
         run_burst($sformatf("rnd%0d", t), $urandom_range(0, NW - 1), $urandom_range(0, NW),
                   (t % 4 == 0) ? 100 : $urandom_range(30, 100), 0, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
